// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key index layout, emulator FSM states, well-known keys.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package keypad_pkg;

    typedef logic [3:0] key_t;

    localparam int ROW_MSB = 3;
    localparam int ROW_LSB = 2;
    localparam int COL_MSB = 1;
    localparam int COL_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam key_t KEY_UP   = 4'h0;
    localparam key_t KEY_DOWN = 4'h8;

    function automatic logic [1:0] key_row(input key_t k);
        return k[ROW_MSB:ROW_LSB];
    endfunction

    function automatic logic [1:0] key_col(input key_t k);
        return k[COL_MSB:COL_LSB];
    endfunction

endpackage

// File: rtl/keypad_emulator_tick_gen.sv
// Free-running prescaler emitting a one-cycle tick every CLK_HZ/TICK_HZ clocks.
// Latency: first tick CLK_HZ/TICK_HZ clocks after reset release.
// Backpressure: none; never restarted, consumers see a fixed-phase tick.
module tick_gen #(
    parameter int CLK_HZ  = 25000000,
    parameter int TICK_HZ = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int PERIOD = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        tick_d = (cnt_q == CNT_W'(PERIOD - 1));
        cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/keypad_emulator.sv
// Keypad device emulator: pulls the commanded key's column low while its row is strobed.
// Latency: row_n edge to col_n is 3 clk; one command at a time, cmd_ready only in IDLE.
// Backpressure: cmd_valid outside IDLE is dropped. Optional contact bounce: KEYPAD_EMU_BOUNCE_EN.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int CLK_HZ    = 25000000,
    parameter int TICK_HZ   = 1000,
    parameter int GAP_TICKS = 5,
    parameter int HOLD_W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        row_n,
    output logic [3:0]        col_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_key,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic              cmd_abort,
    output logic              busy,
    output logic              done
);

    localparam int GAP_W = (GAP_TICKS < 1) ? 1 : $clog2(GAP_TICKS + 1);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_TICKS);

    state_t            state_q, state_d;
    key_t              key_q, key_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              done_q, done_d;
    logic [3:0]        row_meta_q, row_s_q;
    logic [3:0]        col_q, col_d;
    logic              tick;
    logic              drive_en;

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    key_d  = cmd_key;
                    hold_d = cmd_hold;
                    if (cmd_hold == '0) begin
                        state_d = GAP;
                        gap_d   = GAP_INIT;
                    end else begin
                        state_d = PRESS;
                    end
                end
            end
            PRESS: begin
                if (tick && hold_q != '0) hold_d = hold_q - 1'b1;
                // Abort and expiry on the same cycle collapse into one GAP entry.
                if (cmd_abort || (tick && hold_q <= HOLD_W'(1))) begin
                    state_d = GAP;
                    gap_d   = GAP_INIT;
                end
            end
            GAP: begin
                if (tick && gap_q != '0) gap_d = gap_q - 1'b1;
                if (gap_q == '0 || (tick && gap_q == GAP_W'(1))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef KEYPAD_EMU_BOUNCE_EN
    logic [7:0] lfsr_q;
    logic [1:0] bnc_q;
    logic       bounce_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 8'hA5;
            bnc_q  <= 2'd0;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            if (state_d != state_q)
                bnc_q <= 2'd0;
            else if (tick && bnc_q != 2'd3)
                bnc_q <= bnc_q + 2'd1;
        end
    end

    // Bounce window covers the first three ticks after both the make and the break edge.
    always_comb begin
        bounce_on = (bnc_q != 2'd3);
        drive_en  = ((state_q == PRESS) && (!bounce_on || lfsr_q[0])) ||
                    ((state_q == GAP) && bounce_on && lfsr_q[0]);
    end
`else
    always_comb drive_en = (state_q == PRESS);
`endif

    always_comb begin
        col_d = 4'hF;
        if (drive_en && !row_s_q[key_row(key_q)]) col_d[key_col(key_q)] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            key_q      <= '0;
            hold_q     <= '0;
            gap_q      <= '0;
            done_q     <= 1'b0;
            row_meta_q <= 4'hF;
            row_s_q    <= 4'hF;
            col_q      <= 4'hF;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            hold_q     <= hold_d;
            gap_q      <= gap_d;
            done_q     <= done_d;
            row_meta_q <= row_n;
            row_s_q    <= row_meta_q;
            col_q      <= col_d;
        end
    end

    assign col_n     = col_q;
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == PRESS) || (state_q == GAP);
    assign done      = done_q;

endmodule
